// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multi-port register file.
//   DEF_WIDTH / DEF_DEPTH / DEF_NUM_RD : default geometry of regfile_mp
//   ZERO_REG                           : index of the hard-wired zero register
//   addr_live()                        : true when an address names a real,
//                                        writable register (in range, not r0)
package regfile_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;
  localparam int ZERO_REG   = 0;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  function automatic logic addr_live(input int addr, input int depth);
    return (addr != ZERO_REG) && (addr < depth);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one asynchronous read port of regfile_mp.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write forwarding).
// Ports:
//   addr  in   AW             read address
//   mem   in   DEPTH x WIDTH  current register contents
//   wv0/wa0/wd0 in (bypass)   qualified write valid/address/data, port 0
//   wv1/wa1/wd1 in (bypass)   qualified write valid/address/data, port 1
//   rdata out  WIDTH          read data (0 for r0 or out-of-range)
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEF_DEPTH)
) (
  input  logic [AW-1:0]                addr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
`ifdef REGFILE_BYPASS_EN
  input  logic                         wv0,
  input  logic [AW-1:0]                wa0,
  input  logic [WIDTH-1:0]             wd0,
  input  logic                         wv1,
  input  logic [AW-1:0]                wa1,
  input  logic [WIDTH-1:0]             wd1,
`endif
  output logic [WIDTH-1:0]             rdata
);

  always_comb begin
    rdata = '0;
    if (addr_live(int'(addr), DEPTH)) begin
      // Explicit compare loop keeps out-of-range indices from ever
      // reaching the storage select.
      for (int i = 1; i < DEPTH; i++) begin
        if (int'(addr) == i) rdata = mem[i];
      end
`ifdef REGFILE_BYPASS_EN
      // wvN is already gated by range, r0 and reset, so a match here is
      // always a legal forward; port 1 has priority as on the write side.
      if (wv1 && (wa1 == addr)) rdata = wd1;
      else if (wv0 && (wa0 == addr)) rdata = wd0;
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: DEPTH x WIDTH register file, two synchronous write ports and
// NUM_RD asynchronous read ports.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
// Ports:
//   clk         in   1             clock, rising edge
//   rst         in   1             synchronous active-high reset (clears all)
//   reg_write0  in   1             write enable, port 0
//   RW0         in   AW            write address, port 0
//   Bus_W0      in   WIDTH         write data, port 0
//   reg_write1  in   1             write enable, port 1 (wins on collision)
//   RW1         in   AW            write address, port 1
//   Bus_W1      in   WIDTH         write data, port 1
//   RA          in   NUM_RD*AW     packed read addresses, port k at [k*AW +: AW]
//   Bus_R       out  NUM_RD*WIDTH  packed read data, port k at [k*WIDTH +: WIDTH]
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  WIDTH  = DEF_WIDTH,
  parameter int  DEPTH  = DEF_DEPTH,
  parameter int  NUM_RD = DEF_NUM_RD,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reg_write0,
  input  logic [AW-1:0]            RW0,
  input  logic [WIDTH-1:0]         Bus_W0,
  input  logic                     reg_write1,
  input  logic [AW-1:0]            RW1,
  input  logic [WIDTH-1:0]         Bus_W1,
  input  logic [NUM_RD*AW-1:0]     RA,
  output logic [NUM_RD*WIDTH-1:0]  Bus_R
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic                        wv0;
  logic                        wv1;

  // Writes that will actually commit: enabled, legal target, not in reset.
  assign wv0 = reg_write0 && !rst && addr_live(int'(RW0), DEPTH);
  assign wv1 = reg_write1 && !rst && addr_live(int'(RW1), DEPTH);

  // Storage update: r0 is only ever touched by reset, so it stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wv1 && (int'(RW1) == i))      regs[i] <= Bus_W1;
        else if (wv0 && (int'(RW0) == i)) regs[i] <= Bus_W0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_rd (
      .addr  (RA[k*AW +: AW]),
      .mem   (regs),
`ifdef REGFILE_BYPASS_EN
      .wv0   (wv0),
      .wa0   (RW0),
      .wd0   (Bus_W0),
      .wv1   (wv1),
      .wa1   (RW1),
      .wd1   (Bus_W1),
`endif
      .rdata (Bus_R[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed tests plus a model-checked random soak over four
// regfile_mp configurations (32x32 NUM_RD=2, NUM_RD=1, NUM_RD=4, DEPTH=24).
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        we0, we1;
  logic [4:0]  rw0, rw1;
  logic [31:0] w0, w1;
  logic [19:0] ra;
  logic [63:0]  r2;
  logic [31:0]  r1;
  logic [127:0] r4;
  logic [63:0]  r24;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m32 [32];
  logic [31:0] m24 [32];

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2)) dut2 (
    .clk(clk), .rst(rst), .reg_write0(we0), .RW0(rw0), .Bus_W0(w0),
    .reg_write1(we1), .RW1(rw1), .Bus_W1(w1), .RA(ra[9:0]), .Bus_R(r2));
  regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(1)) dut1 (
    .clk(clk), .rst(rst), .reg_write0(we0), .RW0(rw0), .Bus_W0(w0),
    .reg_write1(we1), .RW1(rw1), .Bus_W1(w1), .RA(ra[4:0]), .Bus_R(r1));
  regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(4)) dut4 (
    .clk(clk), .rst(rst), .reg_write0(we0), .RW0(rw0), .Bus_W0(w0),
    .reg_write1(we1), .RW1(rw1), .Bus_W1(w1), .RA(ra), .Bus_R(r4));
  regfile_mp #(.WIDTH(32), .DEPTH(24), .NUM_RD(2)) dut24 (
    .clk(clk), .rst(rst), .reg_write0(we0), .RW0(rw0), .Bus_W0(w0),
    .reg_write1(we1), .RW1(rw1), .Bus_W1(w1), .RA(ra[9:0]), .Bus_R(r24));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; rw0 = '0; rw1 = '0; w0 = '0; w1 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); ra = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    ra = {5'd3, 5'd2, 5'd1, 5'd0};
    #1;
    checks++;
    if (r4 !== 128'h0) begin
      failures++; $display("FAIL reset_clear r4 got=%h exp=0", r4);
    end
    we0 = 1'b1; rw0 = 5'd5; w0 = 32'hDEADBEEF;
    next_cycle();
    idle(); ra = {15'd0, 5'd5};
    #1;
    checks++;
    if (r1 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL reset_prewrite got=%h exp=deadbeef", r1);
    end
    // Reset cycle: a write is presented and must be discarded; reads still
    // show pre-reset contents until the edge.
    rst = 1'b1; we1 = 1'b1; rw1 = 5'd6; w1 = 32'h66666666;
    ra = {10'd0, 5'd6, 5'd5};
    #1;
    checks++;
    if (r1 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL reset_same_cycle got=%h exp=deadbeef", r1);
    end
    checks++;
    if (r2[63:32] !== 32'h0) begin
      failures++; $display("FAIL reset_bypass_suppressed got=%h exp=0", r2[63:32]);
    end
    next_cycle();
    rst = 1'b0; idle();
    #1;
    checks++;
    if (r1 !== 32'h0) begin
      failures++; $display("FAIL reset_r5 got=%h exp=0", r1);
    end
    checks++;
    if (r2[63:32] !== 32'h0) begin
      failures++; $display("FAIL reset_write_dropped got=%h exp=0", r2[63:32]);
    end
  endtask

  task automatic test_basic();
    we0 = 1'b1; rw0 = 5'd7; w0 = 32'h12345678;
    next_cycle();
    idle(); ra = {4{5'd7}};
    #1;
    checks++;
    if (r1 !== 32'h12345678) begin
      failures++; $display("FAIL basic_r1 got=%h exp=12345678", r1);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (r2[k*32 +: 32] !== 32'h12345678) begin
        failures++; $display("FAIL basic_r2_port%0d got=%h exp=12345678", k, r2[k*32 +: 32]);
      end
      checks++;
      if (r24[k*32 +: 32] !== 32'h12345678) begin
        failures++; $display("FAIL basic_r24_port%0d got=%h exp=12345678", k, r24[k*32 +: 32]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (r4[k*32 +: 32] !== 32'h12345678) begin
        failures++; $display("FAIL basic_r4_port%0d got=%h exp=12345678", k, r4[k*32 +: 32]);
      end
    end
  endtask

  task automatic test_collision();
    we0 = 1'b1; rw0 = 5'd9; w0 = 32'h11;
    we1 = 1'b1; rw1 = 5'd9; w1 = 32'h22;
    next_cycle();
    rw0 = 5'd3; w0 = 32'h33;
    rw1 = 5'd4; w1 = 32'h44;
    next_cycle();
    idle(); ra = {5'd7, 5'd4, 5'd3, 5'd9};
    #1;
    checks++;
    if (r4[31:0] !== 32'h22) begin
      failures++; $display("FAIL collision_r9 got=%h exp=22", r4[31:0]);
    end
    checks++;
    if (r4[63:32] !== 32'h33) begin
      failures++; $display("FAIL distinct_r3 got=%h exp=33", r4[63:32]);
    end
    checks++;
    if (r4[95:64] !== 32'h44) begin
      failures++; $display("FAIL distinct_r4 got=%h exp=44", r4[95:64]);
    end
    checks++;
    if (r24[31:0] !== 32'h22) begin
      failures++; $display("FAIL collision_r9_d24 got=%h exp=22", r24[31:0]);
    end
  endtask

  task automatic test_zero_oor();
    we0 = 1'b1; rw0 = 5'd0;  w0 = 32'hFFFF;
    we1 = 1'b1; rw1 = 5'd30; w1 = 32'hAAAA;
    next_cycle();
    idle(); ra = {5'd6, 5'd14, 5'd30, 5'd0};
    #1;
    checks++;
    if (r2[31:0] !== 32'h0) begin
      failures++; $display("FAIL zero_reg got=%h exp=0", r2[31:0]);
    end
    checks++;
    if (r2[63:32] !== 32'hAAAA) begin
      failures++; $display("FAIL r30_depth32 got=%h exp=aaaa", r2[63:32]);
    end
    checks++;
    if (r24[63:32] !== 32'h0) begin
      failures++; $display("FAIL oor_read_depth24 got=%h exp=0", r24[63:32]);
    end
    ra = {10'd0, 5'd6, 5'd14};
    #1;
    checks++;
    if (r24 !== 64'h0) begin
      failures++; $display("FAIL oor_no_alias r14/r6 got=%h exp=0", r24);
    end
    ra = {15'd0, 5'd22};
    #1;
    checks++;
    if (r24[31:0] !== 32'h0) begin
      failures++; $display("FAIL oor_no_alias r22 got=%h exp=0", r24[31:0]);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
    we0 = 1'b1; rw0 = 5'd12; w0 = 32'h1111;
    next_cycle();
    idle();
    we1 = 1'b1; rw1 = 5'd12; w1 = 32'hABCD;
    we0 = 1'b1; rw0 = 5'd12; w0 = 32'h5555;
    ra = {10'd0, 5'd12, 5'd0};
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hABCD;
`else
    exp_same = 32'h1111;
`endif
    #1;
    checks++;
    if (r2[63:32] !== exp_same) begin
      failures++; $display("FAIL bypass_same_cycle got=%h exp=%h", r2[63:32], exp_same);
    end
    next_cycle();
    we0 = 1'b0;
    we1 = 1'b1; rw1 = 5'd0; w1 = 32'h7777;
    #1;
    checks++;
    if (r2[63:32] !== 32'hABCD) begin
      failures++; $display("FAIL bypass_next_cycle got=%h exp=abcd", r2[63:32]);
    end
    checks++;
    if (r2[31:0] !== 32'h0) begin
      failures++; $display("FAIL bypass_r0_excluded got=%h exp=0", r2[31:0]);
    end
    rw1 = 5'd30; w1 = 32'h3030; ra = {10'd0, 5'd30, 5'd30};
    #1;
    checks++;
    if (r24[63:32] !== 32'h0) begin
      failures++; $display("FAIL bypass_oor_excluded got=%h exp=0", r24[63:32]);
    end
    next_cycle();
    idle();
  endtask

  function automatic logic [31:0] exp_rd(input int depth, input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0 || int'(a) >= depth) return 32'h0;
    v = (depth == 24) ? m24[a] : m32[a];
`ifdef REGFILE_BYPASS_EN
    if (!rst) begin
      if (we1 && rw1 == a) v = w1;
      else if (we0 && rw0 == a) v = w0;
    end
`endif
    return v;
  endfunction

  task automatic model_commit(input int depth);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] nv;
      nv = (depth == 24) ? m24[i] : m32[i];
      if (rst) nv = 32'h0;
      else if (i != 0 && i < depth) begin
        if (we1 && int'(rw1) == i) nv = w1;
        else if (we0 && int'(rw0) == i) nv = w0;
      end
      if (depth == 24) m24[i] = nv; else m32[i] = nv;
    end
  endtask

  task automatic test_soak();
    logic [31:0] e;
    for (int c = 0; c < 2000; c++) begin
      next_cycle();
      rst = (c == 0) || ($urandom_range(63) == 0);
      we0 = 1'($urandom_range(1)); we1 = 1'($urandom_range(1));
      rw0 = 5'($urandom_range(31)); rw1 = 5'($urandom_range(31));
      if ($urandom_range(3) == 0) rw1 = rw0;
      w0 = $urandom; w1 = $urandom;
      ra = 20'($urandom);
      if ($urandom_range(2) == 0) ra[9:5] = rw1;
      if ($urandom_range(2) == 0) ra[4:0] = rw0;
      #2;
      if (c > 0) begin
        e = exp_rd(32, ra[4:0]);
        checks++;
        if (r1 !== e) begin
          failures++; $display("FAIL soak_n1 cyc=%0d got=%h exp=%h", c, r1, e);
        end
        for (int k = 0; k < 2; k++) begin
          e = exp_rd(32, ra[k*5 +: 5]);
          checks++;
          if (r2[k*32 +: 32] !== e) begin
            failures++; $display("FAIL soak_n2 cyc=%0d port=%0d got=%h exp=%h", c, k, r2[k*32 +: 32], e);
          end
          e = exp_rd(24, ra[k*5 +: 5]);
          checks++;
          if (r24[k*32 +: 32] !== e) begin
            failures++; $display("FAIL soak_d24 cyc=%0d port=%0d got=%h exp=%h", c, k, r24[k*32 +: 32], e);
          end
        end
        for (int k = 0; k < 4; k++) begin
          e = exp_rd(32, ra[k*5 +: 5]);
          checks++;
          if (r4[k*32 +: 32] !== e) begin
            failures++; $display("FAIL soak_n4 cyc=%0d port=%0d got=%h exp=%h", c, k, r4[k*32 +: 32], e);
          end
        end
      end
      model_commit(32);
      model_commit(24);
    end
    next_cycle();
    rst = 1'b0; idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_zero_oor();
    test_bypass();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
